// File: rtl/cdc_handshake_pkg.sv
// Shared definitions for the four-phase req/ack clock-domain crossing.
// The receive side will import the same defaults so both ends agree.
package cdc_handshake_pkg;

  // Transmit-side handshake FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } tx_state_e;

  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Fewer than two flops on an asynchronous input is not a synchroniser.
  function automatic int clamp_sync_stages(input int n);
    return (n < 2) ? 2 : n;
  endfunction

endpackage

// File: rtl/synchroniser.sv
// Multi-flop synchroniser for signals entering the clk domain.
// Every stage clears to 0 on the asynchronous, active-low reset.
module synchroniser #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Transmitting end of a four-phase req/ack clock-domain crossing.
// Optional handshake timeout: define CDC_HANDSHAKE_TX_TIMEOUT_EN to build it.
//
// Local port handshake: a word transfers on a rising clk edge where
// in_valid and in_ready are both 1. in_ready is 1 only in IDLE and depends on
// state alone; in_valid seen outside IDLE is ignored. Once accepted, tx_data
// is held until the next accepted word.
//
// The FSM state is kept in the signal `state` (type tx_state_e) for probing.
module cdc_handshake_tx
  import cdc_handshake_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             tx_done,
  output logic             timeout_err
);

  localparam int STAGES = clamp_sync_stages(SYNC_STAGES);

  tx_state_e state;
  tx_state_e state_d;

  logic ack_s;
  logic load_data;
  logic req_set;
  logic req_clr;
  logic done_set;
  logic abort;
  logic expire;

  synchroniser #(
    .WIDTH  (1),
    .STAGES (STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tx_ack),
    .q     (ack_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; only the synchronised ack is ever looked at.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)         state_d = SETUP;
      SETUP:   if (!ack_s)           state_d = REQ;
      REQ:     if (ack_s || expire)  state_d = RELEASE;
      RELEASE: if (!ack_s)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output decode: ready flag and strobes for the registered outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    load_data = (state == IDLE) && in_valid;
    req_set   = (state == SETUP) && !ack_s;
    req_clr   = (state == REQ) && (ack_s || expire);
    done_set  = (state == RELEASE) && !ack_s;
    abort     = (state == REQ) && !ack_s && expire;
  end

  // Payload register: only changes when a new word is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         tx_data <= '0;
    else if (load_data) tx_data <= in_data;
  end

  // Request and completion flops; reset drops req without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_req  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if (req_set)      tx_req <= 1'b1;
      else if (req_clr) tx_req <= 1'b0;
      tx_done <= done_set;
    end
  end

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // Abort on the edge where the count would reach TIMEOUT_CYCLES, so the
  // error appears TIMEOUT_CYCLES edges after req rose.
  assign expire = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in REQ; cleared on the edge that raises req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              to_cnt <= '0;
    else if (req_set)        to_cnt <= '0;
    else if (state == REQ)   to_cnt <= to_cnt + CNT_W'(1);
  end

  // One-cycle abort pulse; an ack on the expiry cycle wins and is not an error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= abort;
  end

  assign timeout_err = err_q;
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) & abort;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a simple asynchronous receiver model.
// Build with CDC_HANDSHAKE_TX_TIMEOUT_EN defined to exercise the abort path.
module tb_cdc_handshake_tx;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] tx_data;
  logic         tx_req;
  logic         tx_ack;
  logic         tx_done;
  logic         timeout_err;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .tx_done     (tx_done),
    .timeout_err (timeout_err)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           errors   = 0;
  int           done_cnt = 0;
  int           exp_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- receiver model ----------------
  // Raises ack 3 cycles after seeing req, drops it 3 cycles after req falls.
  logic rx_auto = 1'b1;
  int   rx_hi   = 0;
  int   rx_lo   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_hi = 0;
      rx_lo = 0;
      if (rx_auto) tx_ack = 1'b0;
    end else if (rx_auto) begin
      if (tx_req && !tx_ack) begin
        rx_hi++;
        if (rx_hi == 3) begin tx_ack = 1'b1; rx_hi = 0; end
      end else if (!tx_req && tx_ack) begin
        rx_lo++;
        if (rx_lo == 3) begin tx_ack = 1'b0; rx_lo = 0; end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic         prev_req  = 1'b0;
  logic         prev_done = 1'b0;
  logic [W-1:0] held_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (tx_req && !prev_req) begin
        if (exp_q.size() == 0) check("req_without_word", 1, 0);
        else                   check("data_at_req_rise", tx_data, exp_q.pop_front());
        held_data = tx_data;
      end
      if (!tx_req && prev_req) check("data_stable_during_req", tx_data, held_data);
      if (tx_done) begin
        check("done_single_pulse", prev_done, 0);
        check("ready_with_done", in_ready, 1);
        done_cnt++;
      end
      prev_req  = tx_req;
      prev_done = tx_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done) begin seen = 1'b1; break; end
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, seen, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic         bad;
    logic         seen;
    int           n;
    logic [W-1:0] d;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ack   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_in_ready_during", in_ready, 1);
    check("reset_tx_req_during", tx_req, 0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx_req", tx_req, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_tx_done", tx_done, 0);
    check("reset_timeout_err", timeout_err, 0);

    // Single word: data valid one edge before req rises
    in_data  = 8'hA5;
    in_valid = 1'b1;
    exp_q.push_back(8'hA5);
    exp_done++;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_data_setup", tx_data, 8'hA5);
    check("single_req_low_in_setup", tx_req, 0);
    check("single_busy", in_ready, 0);
    @(negedge clk);
    check("single_req_rise", tx_req, 1);
    wait_done("single_done_seen", 60);
    @(negedge clk);
    check("single_done_cleared", tx_done, 0);
    check("single_ready_back", in_ready, 1);
    check("single_done_count", done_cnt, exp_done);

    // Back-to-back: second word waits for the cycle after tx_done
    in_data  = 8'h01;
    in_valid = 1'b1;
    exp_q.push_back(8'h01);
    exp_done++;
    @(negedge clk);
    in_data = 8'h02;
    exp_q.push_back(8'h02);
    exp_done++;
    check("b2b_ignore_valid", tx_data, 8'h01);
    wait_ready("b2b_ready_seen", 80);
    check("b2b_accept_after_done", tx_done, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_data", tx_data, 8'h02);
    wait_done("b2b_second_done", 60);
    @(negedge clk);
    check("b2b_done_count", done_cnt, exp_done);

    // Stale ack: hold in SETUP until the receiver releases
    rx_auto = 1'b0;
    tx_ack  = 1'b1;
    repeat (4) @(negedge clk);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    exp_q.push_back(8'h3C);
    exp_done++;
    @(negedge clk);
    in_valid = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      if (tx_req !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("stale_hold_setup", bad, 0);
    check("stale_data", tx_data, 8'h3C);
    tx_ack  = 1'b0;
    rx_auto = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (tx_req) begin seen = 1'b1; break; end
    end
    check("stale_req_seen", seen, 1);
    check("stale_req_latency", n, 3);
    wait_done("stale_done", 60);
    @(negedge clk);
    check("stale_done_count", done_cnt, exp_done);

    // Reset while req is high: req falls with no clock edge, no done
    in_data  = 8'h5A;
    in_valid = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_req_up", tx_req, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_req_async", tx_req, 0);
    check("midrst_ready_async", in_ready, 1);
    check("midrst_data_cleared", tx_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt, exp_done);
    check("midrst_ready_after", in_ready, 1);
    check("midrst_req_after", tx_req, 0);

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    // Timeout: ack never comes, abort 16 cycles after req rises
    rx_auto = 1'b0;
    tx_ack  = 1'b0;
    in_data  = 8'h77;
    in_valid = 1'b1;
    exp_q.push_back(8'h77);
    exp_done++;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("to_req_rise", tx_req, 1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) begin seen = 1'b1; break; end
    end
    check("to_err_seen", seen, 1);
    check("to_err_latency", n, 16);
    check("to_req_dropped", tx_req, 0);
    @(negedge clk);
    check("to_done_after_abort", tx_done, 1);
    check("to_err_single_pulse", timeout_err, 0);
    @(negedge clk);
    check("to_ready_back", in_ready, 1);
    rx_auto = 1'b1;
`else
    // No timeout built: req waits indefinitely
    rx_auto = 1'b0;
    tx_ack  = 1'b0;
    in_data  = 8'h77;
    in_valid = 1'b1;
    exp_q.push_back(8'h77);
    exp_done++;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    bad = 1'b0;
    repeat (100) begin
      if (tx_req !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("noto_req_held", bad, 0);
    rx_auto = 1'b1;
    wait_done("noto_late_ack_done", 40);
`endif

    // Random payloads through the normal handshake
    for (int k = 0; k < 4; k++) begin
      wait_ready("rand_ready", 40);
      d = W'($urandom_range(0, 255));
      in_data  = d;
      in_valid = 1'b1;
      exp_q.push_back(d);
      exp_done++;
      @(negedge clk);
      in_valid = 1'b0;
      check("rand_data_loaded", tx_data, d);
      wait_done("rand_done", 60);
    end

    repeat (2) @(negedge clk);
    check("final_done_count", done_cnt, exp_done);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Transmitting end of a four-phase req/ack clock-domain crossing. It accepts a WIDTH-bit word on a local valid/ready port in the `clk` domain and presents it on `tx_data`, holding it stable. It then runs the `tx_req`/`tx_ack` handshake with an asynchronous receiver, synchronising `tx_ack` internally. It sits at the boundary where analyser results leave the `clk` domain for host-side or mechanism-side logic.

## Interface
Parameters:
- WIDTH, 8, payload width in bits.
- SYNC_STAGES, 2, flip-flop stages on `tx_ack`; minimum 2.
- TIMEOUT_CYCLES, 1024, `clk` cycles allowed in REQ before abort; used only when the timeout feature is compiled in.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to send.
- in_valid  input  1  `in_data` valid.
- in_ready  output  1  block can accept a word.
- tx_data  output  WIDTH  registered payload to the receiver.
- tx_req  output  1  registered request to the receiver.
- tx_ack  input  1  asynchronous acknowledge from the receiver.
- tx_done  output  1  one-cycle pulse when a handshake completes.
- timeout_err  output  1  one-cycle pulse when a handshake is aborted; constant 0 when timeout is compiled out.

## Operation
- FSM states: IDLE, SETUP, REQ, RELEASE.
- `ack_s` is `tx_ack` after SYNC_STAGES flops. Only `ack_s` is used by the FSM.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, load `tx_data <= in_data` and go to SETUP.
- SETUP:
  - `tx_req` stays 0.
  - If `ack_s` = 0, set `tx_req <= 1` and go to REQ.
  - Otherwise stay in SETUP until the receiver releases a stale ack.
- REQ:
  - Hold `tx_req` = 1 and `tx_data` stable.
  - On `ack_s` = 1, set `tx_req <= 0` and go to RELEASE.
- RELEASE:
  - On `ack_s` = 0, pulse `tx_done` and go to IDLE.
- `in_ready` is 1 only in IDLE and is combinational from state.
- `tx_data` changes only on the IDLE→SETUP transition. It keeps its last value afterwards.
- A transfer is in progress in SETUP, REQ and RELEASE; `in_valid` is ignored in these states.
- Reset values: state IDLE, `tx_req` 0, `tx_data` 0, `tx_done` 0, `timeout_err` 0, sync flops 0, timeout counter 0. `in_ready` = 1 while reset is asserted.
- Reset mid-transfer: `tx_req` falls asynchronously and the word is discarded. No `tx_done` is generated.

## Timing
- Accept at edge k: `tx_data` is valid after edge k.
- `tx_req` rises after edge k+1, provided `ack_s` = 0. This gives at least one cycle of data setup before req.
- `tx_ack` rising reaches `ack_s` SYNC_STAGES edges later. `tx_req` falls on the following edge.
- `tx_done` is high for exactly the cycle after the edge that sees `ack_s` fall.
- IDLE is entered on that same edge, so the next word can be accepted on the next edge.
- Minimum period per word: 4 + 2·SYNC_STAGES cycles plus receiver latency.

## Configuration
- Macro: `CDC_HANDSHAKE_TX_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYCLES with `ack_s` still 0, `tx_req <= 0`, `timeout_err` pulses for one cycle, and the FSM goes to RELEASE.
  - RELEASE then returns to IDLE normally once `ack_s` = 0, and `tx_done` pulses.
  - `ack_s` = 1 on the expiry cycle takes priority as a normal acknowledge, with no error.
- Undefined: no counter is built, REQ waits indefinitely, and `timeout_err` is tied to 0.

## Structure
- Shared package `cdc_handshake_pkg` holds:
  - `tx_state_e`, the enum {IDLE, SETUP, REQ, RELEASE};
  - the default constants for SYNC_STAGES and TIMEOUT_CYCLES, shared with the future receive side.
- Sub-module: the existing `synchroniser`, instantiated with WIDTH=1 and STAGES=SYNC_STAGES on `tx_ack`.

## Test plan
- Reset: hold reset low, then release. Required: `tx_req`=0, `tx_data`=0, `in_ready`=1, `tx_done`=0, `timeout_err`=0.
- Single word: `in_data`=0xA5 with `in_valid` for 1 cycle; receiver model acks 3 cycles after req and drops ack 3 cycles after req falls. Required: `tx_data`=0xA5 one edge before `tx_req` rises; `tx_done` is a single pulse; `in_ready` returns to 1.
- Back-to-back: `in_valid` held with 0x01 then 0x02. Required: 0x02 is accepted only in the cycle after `tx_done`; `tx_data` never changes while `tx_req`=1; two `tx_done` pulses.
- Stale ack: `tx_ack` held 1 when 0x3C is accepted. Required: FSM stays in SETUP with `tx_req`=0 until ack falls, then the normal handshake completes.
- Reset mid-transfer: assert reset while `tx_req`=1. Required: `tx_req` drops to 0 without a clock edge; no `tx_done`; `in_ready`=1 after release.
- Timeout (macro defined, TIMEOUT_CYCLES=16, `tx_ack` tied 0): required `timeout_err` pulse 16 cycles after `tx_req` rises, `tx_req`=0, then `tx_done` and IDLE. With the macro undefined, `tx_req` stays 1 for 100 cycles and `timeout_err` stays 0.
